// File: rtl/wb_arbiter_pkg.sv
// Shared widths, FSM encoding and payload record for the writeback arbiter.
// Width macros keep their usual values unless the surrounding build defines them.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef WB_OPCODE_WIDTH
`define WB_OPCODE_WIDTH 8
`endif
`ifndef WB_REG_WIDTH
`define WB_REG_WIDTH 4
`endif
`ifndef ARB_ST_IDLE
`define ARB_ST_IDLE 1'b0
`endif
`ifndef ARB_ST_HOLD
`define ARB_ST_HOLD 1'b1
`endif

package wb_arbiter_pkg;
  localparam int DATA_W   = `DATA_WIDTH;
  localparam int ADDR_W   = `ADDRESS_WIDTH;
  localparam int OPCODE_W = `WB_OPCODE_WIDTH;
  localparam int REG_W    = `WB_REG_WIDTH;

  typedef enum logic {
    ST_ARB_IDLE = `ARB_ST_IDLE,
    ST_ARB_HOLD = `ARB_ST_HOLD
  } arb_state_e;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [DATA_W-1:0]   val;
    logic [REG_W-1:0]    dest_reg;
    logic [ADDR_W-1:0]   dest_addr;
  } wb_payload_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/wb_arbiter_if.sv
// Request and writeback bundle between the exec-stage producers, the arbiter and writeback.
// The master modport is the arbiter's view; slave is the producers/writeback view.
interface wb_arbiter_if import wb_arbiter_pkg::*; #(parameter int NUM_REQ = 2);
  logic [NUM_REQ-1:0]          req_valid;
  logic [OPCODE_W*NUM_REQ-1:0] req_opcode;
  logic [DATA_W*NUM_REQ-1:0]   req_val;
  logic [REG_W*NUM_REQ-1:0]    req_dest_reg;
  logic [ADDR_W*NUM_REQ-1:0]   req_dest_addr;
  logic [NUM_REQ-1:0]          req_ready;
  logic                        flush;
  logic                        wb_valid;
  logic [OPCODE_W-1:0]         wb_opcode;
  logic [DATA_W-1:0]           wb_val;
  logic [REG_W-1:0]            wb_dest_reg;
  logic [ADDR_W-1:0]           wb_dest_addr;
  logic                        wb_ready;

  modport master (
    input  req_valid, req_opcode, req_val, req_dest_reg, req_dest_addr, flush, wb_ready,
    output req_ready, wb_valid, wb_opcode, wb_val, wb_dest_reg, wb_dest_addr
  );

  modport slave (
    output req_valid, req_opcode, req_val, req_dest_reg, req_dest_addr, flush, wb_ready,
    input  req_ready, wb_valid, wb_opcode, wb_val, wb_dest_reg, wb_dest_addr
  );
endinterface

// File: rtl/wb_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request scanning upward from ptr, wrapping.
// ptr must be below NUM_REQ; the PTR_W+1 bit sum absorbs the wrap without a modulo.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic               any_valid,
  output logic [PTR_W-1:0]   grant
);
  logic [PTR_W:0] idx;

  always_comb begin
    any_valid = 1'b0;
    grant     = '0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr} + (PTR_W+1)'(i);
      if (idx >= (PTR_W+1)'(NUM_REQ)) idx = idx - (PTR_W+1)'(NUM_REQ);
      if (!any_valid && req[idx[PTR_W-1:0]]) begin
        any_valid = 1'b1;
        grant     = idx[PTR_W-1:0];
      end
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing the single writeback port among NUM_REQ producers.
// Optional WB_ARB_STATS_EN adds per-requester transfer counters and a stall counter.
module wb_arbiter import wb_arbiter_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic             clk,
  input  logic             reset,
  wb_arbiter_if.master     bus,
  output logic [PTR_W-1:0] grant_id,
  output logic             busy
`ifdef WB_ARB_STATS_EN
  ,
  output logic [16*NUM_REQ-1:0] grant_cnt,
  output logic [15:0]           stall_cnt
`endif
);
  arb_state_e       state, state_nxt;
  logic [PTR_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [PTR_W-1:0] ptr_after, pick_ptr, pick_grant;
  logic             pick_any, transfer, capture;
  wb_payload_t      held, req_sel;

  assign transfer  = (state == ST_ARB_HOLD) && bus.wb_ready;
  assign ptr_after = (grant_id == PTR_W'(NUM_REQ-1)) ? '0 : grant_id + PTR_W'(1);
  // In HOLD the only arbitration that matters is the back-to-back one after a transfer,
  // which must already see the advanced pointer.
  assign pick_ptr  = (state == ST_ARB_HOLD) ? ptr_after : rr_ptr;

  rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_picker (
    .req       (bus.req_valid),
    .ptr       (pick_ptr),
    .any_valid (pick_any),
    .grant     (pick_grant)
  );

  always_comb begin
    req_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_grant == PTR_W'(k)) begin
        req_sel.opcode    = bus.req_opcode[k*OPCODE_W +: OPCODE_W];
        req_sel.val       = bus.req_val[k*DATA_W +: DATA_W];
        req_sel.dest_reg  = bus.req_dest_reg[k*REG_W +: REG_W];
        req_sel.dest_addr = bus.req_dest_addr[k*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    capture       = 1'b0;
    bus.req_ready = '0;
    case (state)
      ST_ARB_IDLE: begin
        if (!bus.flush && pick_any) capture = 1'b1;
      end
      ST_ARB_HOLD: begin
        if (transfer) begin
          rr_ptr_nxt = ptr_after;
          if (!bus.flush && pick_any) capture = 1'b1;
        end
      end
      default: ;
    endcase
    if (reset) capture = 1'b0;
    if (capture) begin
      state_nxt     = ST_ARB_HOLD;
      bus.req_ready = NUM_REQ'(1) << pick_grant;
    end else if (bus.flush || transfer) begin
      state_nxt = ST_ARB_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_ARB_IDLE;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      held     <= '0;
      grant_id <= '0;
    end else if (capture) begin
      held     <= req_sel;
      grant_id <= pick_grant;
    end
  end

  assign bus.wb_valid     = (state == ST_ARB_HOLD);
  assign bus.wb_opcode    = held.opcode;
  assign bus.wb_val       = held.val;
  assign bus.wb_dest_reg  = held.dest_reg;
  assign bus.wb_dest_addr = held.dest_addr;
  assign busy             = (state != ST_ARB_IDLE);

`ifdef WB_ARB_STATS_EN
  logic [15:0] gcnt [NUM_REQ];
  logic [15:0] stall_q;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_REQ; k++) gcnt[k] <= '0;
      stall_q <= '0;
    end else begin
      if (transfer) gcnt[grant_id] <= sat_inc16(gcnt[grant_id]);
      if (bus.wb_valid && !bus.wb_ready) stall_q <= sat_inc16(stall_q);
    end
  end

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_cnt
    assign grant_cnt[16*k +: 16] = gcnt[k];
  end
  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed plus randomized bench for wb_arbiter against a cycle-level behavioural model.
// Covers the WB_ARB_STATS_EN counters when that macro is defined.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;
  localparam int N = 2;
  localparam int P = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [P-1:0] grant_id;
  logic busy;
`ifdef WB_ARB_STATS_EN
  logic [16*N-1:0] grant_cnt;
  logic [15:0]     stall_cnt;
`endif

  wb_arbiter_if #(.NUM_REQ(N)) bus();

  wb_arbiter #(.NUM_REQ(N), .PTR_W(P)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy)
`ifdef WB_ARB_STATS_EN
    ,
    .grant_cnt(grant_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit                  rq_valid [N];
  logic [OPCODE_W-1:0] rq_op    [N];
  logic [DATA_W-1:0]   rq_val   [N];
  logic [REG_W-1:0]    rq_reg   [N];
  logic [ADDR_W-1:0]   rq_addr  [N];

  bit          m_held;
  int          m_owner;
  int          m_ptr;
  wb_payload_t m_pay;
`ifdef WB_ARB_STATS_EN
  int m_gcnt [N];
  int m_stall;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_req(input int k);
    rq_valid[k] = 1'b1;
    rq_op[k]    = OPCODE_W'($urandom);
    rq_val[k]   = DATA_W'($urandom);
    rq_reg[k]   = REG_W'($urandom);
    rq_addr[k]  = ($urandom_range(0, 3) == 0) ? '0 : ADDR_W'($urandom);
  endtask

  // One clock: drive at negedge, check the combinational ready, then check registered outputs.
  task automatic step(input bit fl, input bit wbr, input bit rst);
    int p;
    int g;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    reset        = rst;
    bus.flush    = fl;
    bus.wb_ready = wbr;
    for (int k = 0; k < N; k++) begin
      bus.req_valid[k]                        = rq_valid[k];
      bus.req_opcode[k*OPCODE_W +: OPCODE_W]  = rq_op[k];
      bus.req_val[k*DATA_W +: DATA_W]         = rq_val[k];
      bus.req_dest_reg[k*REG_W +: REG_W]      = rq_reg[k];
      bus.req_dest_addr[k*ADDR_W +: ADDR_W]   = rq_addr[k];
    end
    #1;
    g = -1;
    if (!rst && !fl && (!m_held || wbr)) begin
      p = (m_held && wbr) ? (m_owner + 1) % N : m_ptr;
      for (int i = 0; i < N; i++)
        if (g < 0 && rq_valid[(p + i) % N]) g = (p + i) % N;
    end
    exp_ready = (g >= 0) ? (N'(1) << g) : '0;
    chk("req_ready", bus.req_ready, exp_ready);
    @(posedge clk);
    if (rst) begin
      m_held = 1'b0; m_owner = 0; m_ptr = 0; m_pay = '0;
`ifdef WB_ARB_STATS_EN
      for (int k = 0; k < N; k++) m_gcnt[k] = 0;
      m_stall = 0;
`endif
    end else begin
`ifdef WB_ARB_STATS_EN
      if (m_held && !wbr && m_stall < 65535) m_stall++;
      if (m_held && wbr && m_gcnt[m_owner] < 65535) m_gcnt[m_owner]++;
`endif
      if (m_held && wbr) begin
        m_ptr  = (m_owner + 1) % N;
        m_held = 1'b0;
      end
      if (fl) m_held = 1'b0;
      if (g >= 0) begin
        m_held  = 1'b1;
        m_owner = g;
        m_pay   = '{opcode: rq_op[g], val: rq_val[g], dest_reg: rq_reg[g], dest_addr: rq_addr[g]};
        rq_valid[g] = 1'b0;
      end
    end
    #1;
    chk("wb_valid", bus.wb_valid, m_held);
    chk("busy", busy, m_held);
    chk("grant_id", grant_id, m_owner);
    if (m_held || rst) begin
      chk("wb_opcode", bus.wb_opcode, m_pay.opcode);
      chk("wb_val", bus.wb_val, m_pay.val);
      chk("wb_dest_reg", bus.wb_dest_reg, m_pay.dest_reg);
      chk("wb_dest_addr", bus.wb_dest_addr, m_pay.dest_addr);
    end
`ifdef WB_ARB_STATS_EN
    for (int k = 0; k < N; k++) chk("grant_cnt", grant_cnt[16*k +: 16], m_gcnt[k]);
    chk("stall_cnt", stall_cnt, m_stall);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.flush = 1'b0; bus.wb_ready = 1'b0; bus.req_valid = '0;
    bus.req_opcode = '0; bus.req_val = '0; bus.req_dest_reg = '0; bus.req_dest_addr = '0;
    for (int k = 0; k < N; k++) begin
      rq_valid[k] = 1'b0; rq_op[k] = '0; rq_val[k] = '0; rq_reg[k] = '0; rq_addr[k] = '0;
    end
    m_held = 1'b0; m_owner = 0; m_ptr = 0; m_pay = '0;
`ifdef WB_ARB_STATS_EN
    for (int k = 0; k < N; k++) m_gcnt[k] = 0;
    m_stall = 0;
`endif

    // Reset, then both requesters streaming with writeback always ready: 0,1,0,1.
    step(0, 0, 1);
    step(0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < N; k++) if (!rq_valid[k]) new_req(k);
      step(0, 1, 0);
      chk("rr_order", grant_id, i % 2);
    end
    for (int k = 0; k < N; k++) rq_valid[k] = 1'b0;
    step(0, 1, 0);
    step(0, 1, 0);

    // Requester 0 alone, 0x5A, four stall cycles then transfer.
    new_req(0);
    rq_val[0] = DATA_W'(32'h5A);
    step(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0);
      chk("hold_val", bus.wb_val, 32'h5A);
    end
    step(0, 1, 0);
    chk("drop_after_xfer", bus.wb_valid, 1'b0);

    // Pointer now at 1: requester 1 wins first, then wrap back to 0.
    new_req(0);
    new_req(1);
    step(0, 1, 0);
    chk("ptr1_first", grant_id, 1);
    step(0, 1, 0);
    chk("wrap_to_0", grant_id, 0);

    // Flush while holding with writeback stalled; pointer must not move.
    step(0, 0, 0);
    new_req(1);
    step(1, 0, 0);
    chk("flush_valid", bus.wb_valid, 1'b0);
    new_req(0);
    step(0, 0, 0);
    chk("flush_ptr", grant_id, 0);

    // Reset mid-hold with requester 1 pending.
    step(0, 0, 1);
    chk("rst_valid", bus.wb_valid, 1'b0);
    step(0, 0, 0);
    chk("post_rst_grant", grant_id, 1);
    step(0, 1, 0);
    step(0, 1, 0);

    // Randomized traffic, flushes, stalls and occasional reset.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++)
        if (!rq_valid[k] && $urandom_range(0, 2) != 0) new_req(k);
      step($urandom_range(0, 15) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 99) == 0);
    end

`ifdef WB_ARB_STATS_EN
    // Ten transfers from requester 0 with three stall cycles.
    for (int k = 0; k < N; k++) rq_valid[k] = 1'b0;
    step(0, 0, 1);
    new_req(0);
    step(0, 1, 0);
    for (int i = 0; i < 13; i++) begin
      if (!rq_valid[0]) new_req(0);
      step(0, !(i == 2 || i == 6 || i == 9), 0);
    end
    chk("stats_grant0", grant_cnt[15:0], 10);
    chk("stats_stall", stall_cnt, 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
